mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port: converts single load/store requests from the CPU datapath into MemRead/MemWrite/Address/WriteData cycles and collects ReadData.
- The memory it drives has combinational read and write-on-posedge, word-addressed by Address[7:2].
- Adds byte/halfword access (read-modify-write for sub-word stores), sign/zero extension, and alignment/range checking.
- Sits between the execute stage and the data memory.

---
 rtl/mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns single load/store requests into MemRead/MemWrite cycles, with sub-word support.
// Latency: error 1 cycle, load and word store 2 cycles, sub-word store 3 cycles from accept to resp_valid.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time; responses cannot be stalled.
//
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   req_*                - request handshake (valid/ready), kind, size, sign, byte address, store data
//   resp_*               - one-cycle completion pulse with extended load data and error flag
//   MemRead/MemWrite/Address/WriteData/ReadData - attached memory (combinational read, write on posedge)
//   stat_loads/stat_stores/stat_errs - saturating response counters, present only when
//                          MEM_ACCESS_STATS_EN is defined
module mem_access_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  // Compared at 33 bits so addresses near 2^32 cannot wrap below the limit.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        ready_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] address_q;
  logic [31:0] write_data_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Request legality, evaluated on the raw request at accept time.
  logic req_err;
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  // Lane position of the registered access; halfwords are known to be
  // 2-byte aligned here, so the byte shift also covers them.
  logic [4:0]  lane_shift;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    rd_shifted = ReadData >> lane_shift;
    load_data  = ReadData;
    lane_mask  = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        load_data = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                             : {24'd0, rd_shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      2'b01: begin
        load_data = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                             : {16'd0, rd_shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: begin
        load_data = ReadData;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged_word = (ReadData & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // FSM with registered outputs: each transition loads the output values
  // belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      ready_q      <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      ready_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_write && (req_size == 2'b10)) begin
              state_q      <= S_WR;
              mem_write_q  <= 1'b1;
              address_q    <= {req_addr[31:2], 2'b00};
              write_data_q <= req_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state_q    <= S_RD;
              mem_read_q <= 1'b1;
              address_q  <= {req_addr[31:2], 2'b00};
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_RD: begin
          if (write_q) begin
            state_q      <= S_WR;
            mem_write_q  <= 1'b1;
            address_q    <= {addr_q[31:2], 2'b00};
            write_data_q <= merged_word;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
          end
        end
        S_WR: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign MemRead    = mem_read_q;
  // Reset seen during WR must stop the write landing on that same edge.
  assign MemWrite   = mem_write_q & ~reset;
  assign Address    = address_q;
  assign WriteData  = write_data_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads_q;
  logic [15:0] stat_stores_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads_q  <= 16'd0;
      stat_stores_q <= 16'd0;
      stat_errs_q   <= 16'd0;
    end else if (resp_valid_q) begin
      if (resp_err_q) begin
        if (stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
      end else if (write_q) begin
        if (stat_stores_q != 16'hFFFF) stat_stores_q <= stat_stores_q + 16'd1;
      end else begin
        if (stat_loads_q != 16'hFFFF) stat_loads_q <= stat_loads_q + 16'd1;
      end
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: attached word memory plus a byte-level reference model.
// Latency and ordering are checked against expectations derived from the access rules.
// Requests are either one at a time or held back-to-back while the controller is busy.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
`ifdef MEM_ACCESS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, write on posedge, indexed by Address[7:2].
  logic [31:0] mem [64];
  assign ReadData = mem[Address[7:2]];
  always @(posedge clk) if (MemWrite) mem[Address[7:2]] <= WriteData;

  // Reference model: plain byte array, same word indexing as the memory.
  logic [7:0] ref_bytes [256];

  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat,
                              output logic [31:0] new_word);
    int nb;
    logic [31:0] v;
    logic [7:0] base;
    er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
         (a >= 32'd1024);
    rd = 32'd0;
    new_word = 32'd0;
    lat = 1;
    if (!er) begin
      nb = 1 << sz;
      base = a[7:0];
      if (w) begin
        for (int i = 0; i < nb; i++) ref_bytes[base + 8'(i)] = wd[8*i +: 8];
        lat = (sz == 2'd2) ? 2 : 3;
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_bytes[base + 8'(i)]) << (8*i));
        if (sg && nb < 4 && v >= (32'd1 << (8*nb - 1))) v = v - (32'd1 << (8*nb));
        rd = v;
        lat = 2;
      end
      for (int i = 0; i < 4; i++) new_word[8*i +: 8] = ref_bytes[{base[7:2], 2'(i)}];
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx] = val;
    for (int i = 0; i < 4; i++) ref_bytes[4*idx + i] = val[8*i +: 8];
  endtask

  // Runs one request and collects what the bus and response showed.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nrd, output int nwr, output logic [31:0] wd_seen,
                         output logic [31:0] adr_seen, output int proto_bad,
                         output logic timeout);
    logic accepted, done;
    rd = 32'd0; er = 1'b0; lat = 0; nrd = 0; nwr = 0; wd_seen = 32'd0;
    adr_seen = 32'd0; proto_bad = 0; timeout = 1'b0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!accepted) begin timeout = 1'b1; return; end
    done = 1'b0;
    for (int k = 1; k <= 10 && !done; k++) begin
      @(negedge clk);
      if (MemRead) begin nrd++; adr_seen = Address; end
      if (MemWrite) begin nwr++; adr_seen = Address; wd_seen = WriteData; end
      if (MemRead && MemWrite) proto_bad++;
      if (req_ready) proto_bad++;
      if (!MemRead && !MemWrite && (Address != 0 || WriteData != 0)) proto_bad++;
      if (resp_valid) begin
        done = 1'b1; lat = k; rd = resp_rdata; er = resp_err;
      end else if (resp_rdata != 0 || resp_err) proto_bad++;
      @(posedge clk); #1;
    end
    if (!done) timeout = 1'b1;
  endtask

  // Runs a request and compares everything against the model.
  task automatic checked_req(input string name, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd, wd_seen, adr_seen, exp_word;
    logic er, exp_er, to;
    int lat, exp_lat, nrd, nwr, bad, exp_nrd, exp_nwr;
    model_access(w, sz, sg, a, wd, exp_rd, exp_er, exp_lat, exp_word);
    exp_nrd = (!exp_er && (!w || sz != 2'd2)) ? 1 : 0;
    exp_nwr = (!exp_er && w) ? 1 : 0;
    run_req(w, sz, sg, a, wd, rd, er, lat, nrd, nwr, wd_seen, adr_seen, bad, to);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL %s timeout: got %0b want 0", name, to);
    end
    vectors++;
    if (rd !== exp_rd || er !== exp_er) begin
      miscompares++;
      $display("FAIL %s resp: got rdata=%h err=%0b want rdata=%h err=%0b", name, rd, er, exp_rd, exp_er);
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    vectors++;
    if (nrd !== exp_nrd || nwr !== exp_nwr) begin
      miscompares++;
      $display("FAIL %s bus cycles: got rd=%0d wr=%0d want rd=%0d wr=%0d", name, nrd, nwr, exp_nrd, exp_nwr);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL %s protocol: got %0d violations want 0", name, bad);
    end
    if (exp_nrd + exp_nwr > 0) begin
      vectors++;
      if (adr_seen !== {a[31:2], 2'b00}) begin
        miscompares++; $display("FAIL %s Address: got %h want %h", name, adr_seen, {a[31:2], 2'b00});
      end
    end
    if (exp_nwr > 0) begin
      vectors++;
      if (wd_seen !== exp_word) begin
        miscompares++; $display("FAIL %s WriteData: got %h want %h", name, wd_seen, exp_word);
      end
    end
  endtask

  task automatic gen_req(output logic w, output logic [1:0] sz, output logic sg,
                         output logic [31:0] a, output logic [31:0] wd);
    int r;
    r = $urandom_range(0, 99);
    sz = (r < 5) ? 2'd3 : 2'($urandom_range(0, 2));
    a = 32'($urandom_range(0, 255));
    if (r >= 5 && r < 88 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
    if (r >= 94) a = 32'h400 + 32'($urandom_range(0, 65535));
    if (r >= 98) a = $urandom() | 32'h8000_0000;
    w = 1'($urandom_range(0, 1));
    sg = 1'($urandom_range(0, 1));
    wd = $urandom();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset handshake: got ready=%0b vld=%0b rdata=%h err=%0b want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    vectors++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Address !== 32'd0 || WriteData !== 32'd0) begin
      miscompares++;
      $display("FAIL reset bus: got rd=%0b wr=%0b addr=%h wdata=%h want all 0",
               MemRead, MemWrite, Address, WriteData);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load;
    checked_req("word_load_0x4", 1'b0, 2'd2, 1'b0, 32'h4, 32'd0);
  endtask

  task automatic test_word_store;
    checked_req("word_store_0x8", 1'b1, 2'd2, 1'b0, 32'h8, 32'h0000_000F);
    checked_req("word_load_0x8", 1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
  endtask

  task automatic test_subword;
    checked_req("byte_store_0x1", 1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_0080);
    checked_req("byte_load_signed", 1'b0, 2'd0, 1'b1, 32'h1, 32'd0);
    checked_req("byte_load_unsigned", 1'b0, 2'd0, 1'b0, 32'h1, 32'd0);
    checked_req("half_store_0x6", 1'b1, 2'd1, 1'b0, 32'h6, 32'hABCD_9234);
    checked_req("half_load_signed_0x6", 1'b0, 2'd1, 1'b1, 32'h6, 32'd0);
  endtask

  task automatic test_errors;
    checked_req("err_half_0x3", 1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
    checked_req("err_word_0x400", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
    checked_req("err_size3", 1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
    checked_req("err_store_word_0x3fe", 1'b1, 2'd2, 1'b0, 32'h3FE, 32'h1234_5678);
  endtask

  task automatic test_reset_during_wr;
    logic accepted;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h1234_5678;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    vectors++;
    if (MemWrite !== 1'b1) begin
      miscompares++; $display("FAIL rst_wr entered WR: got MemWrite=%0b want 1", MemWrite);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (MemWrite !== 1'b0) begin
      miscompares++; $display("FAIL rst_wr gated write: got MemWrite=%0b want 0", MemWrite);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0 ||
        Address !== 32'd0 || WriteData !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wr after reset: got ready=%0b vld=%0b rd=%0b wr=%0b addr=%h want 1 0 0 0 0",
               req_ready, resp_valid, MemRead, MemWrite, Address);
    end
    vectors++;
    if (mem[2] !== 32'h0000_000F) begin
      miscompares++; $display("FAIL rst_wr word2: got %h want 0000000f", mem[2]);
    end
    @(posedge clk); #1;
    checked_req("rst_wr_reload_0x8", 1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
  endtask

  task automatic test_random;
    logic w, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;
    for (int i = 0; i < 150; i++) begin
      gen_req(w, sz, sg, a, wd);
      checked_req("random", w, sz, sg, a, wd);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 30;
    logic w, sg, pending, acc_now;
    logic [1:0] sz;
    logic [31:0] a, wd, exp_rd, exp_word;
    logic exp_er;
    int lat, n_acc, n_resp;
    logic [32:0] exp_q [$];
    n_acc = 0; n_resp = 0; pending = 1'b0;
    gen_req(w, sz, sg, a, wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    for (int cyc = 0; cyc < 400 && n_resp < N; cyc++) begin
      acc_now = 1'b0;
      @(negedge clk);
      if (pending) begin
        vectors++;
        if (req_ready !== 1'b0) begin
          miscompares++; $display("FAIL b2b ready while busy: got %0b want 0", req_ready);
        end
        if (resp_valid) begin
          vectors++;
          if ({resp_err, resp_rdata} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL b2b resp %0d: got err=%0b rdata=%h want err=%0b rdata=%h",
                     n_resp, resp_err, resp_rdata, exp_q[0][32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
          n_resp++;
          pending = 1'b0;
        end
      end else begin
        vectors++;
        if (resp_valid !== 1'b0) begin
          miscompares++; $display("FAIL b2b response while idle: got %0b want 0", resp_valid);
        end
        if (req_ready && n_acc < N) begin
          model_access(w, sz, sg, a, wd, exp_rd, exp_er, lat, exp_word);
          exp_q.push_back({exp_er, exp_rd});
          n_acc++;
          pending = 1'b1;
          acc_now = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (n_acc < N) begin
          gen_req(w, sz, sg, a, wd);
          req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (n_resp !== N) begin
      miscompares++; $display("FAIL b2b response count: got %0d want %0d", n_resp, N);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) preload(i, $urandom());
    preload(0, 32'd5);
    preload(1, 32'd10);
    preload(2, 32'd0);
    test_reset;
    test_word_load;
    test_word_store;
    test_subword;
    test_errors;
    test_reset_during_wr;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
